// File: rtl/tx_fifo.sv
// tx_fifo: single-clock 128-to-8 width-converting transmit FIFO.
// Whole words go in and come out one byte at a time, lane 0 first.
// A word keeps its entry until its last lane has been read.
module tx_fifo #(
    parameter int WR_DEPTH_WIDTH   = 8,
    parameter int WR_DATA_WIDTH    = 128,
    parameter int RD_DEPTH_WIDTH   = 12,
    parameter int RD_DATA_WIDTH    = 8,
    parameter int ALMOST_FULL_NUM  = 255,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level
);

    // Byte-lane index width inside one word, and lanes per word.
    localparam int LANE_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
    localparam int RATIO  = WR_DATA_WIDTH / RD_DATA_WIDTH;
    localparam int WORDS  = 1 << WR_DEPTH_WIDTH;

    localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] AF_LVL   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [RD_DEPTH_WIDTH:0] AE_LVL   = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    // Write pointer counts words, read pointer counts bytes; both carry a wrap bit.
    logic [WR_DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d;
    logic [RD_DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d;
    logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WR_DATA_WIDTH-1:0] mem [WORDS];
    logic [RATIO-1:0][RD_DATA_WIDTH-1:0] rd_word;
    logic wr_accept, rd_accept;

    // Levels and flags decode straight from the pointer registers.
    always_comb begin
        wr_water_level = wr_ptr_q - rd_ptr_q[RD_DEPTH_WIDTH:LANE_W];
        rd_water_level = {wr_ptr_q, {LANE_W{1'b0}}} - rd_ptr_q;
        wr_full        = (wr_water_level == FULL_LVL);
        almost_full    = (wr_water_level >= AF_LVL);
        rd_empty       = (rd_water_level == '0);
        almost_empty   = (rd_water_level <= AE_LVL);
    end

    // Accept decisions and next-state for pointers and the output byte.
    // A read and a write never touch the same entry in one cycle: equal
    // indices only happen when empty (read blocked) or full (write blocked).
    always_comb begin
        wr_accept = wr_en && !wr_full && !rst;
        rd_accept = rd_en && !rd_empty && !rst;
        rd_word   = mem[rd_ptr_q[RD_DEPTH_WIDTH-1:LANE_W]];
        wr_ptr_d  = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = rd_accept ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d = rd_accept ? rd_word[rd_ptr_q[LANE_W-1:0]] : rd_data_q;
    end

    // Pointer and output registers; reset discards all stored data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Word storage; contents are left as-is across reset.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q[WR_DEPTH_WIDTH-1:0]] <= wr_data;
    end

    assign rd_data = rd_data_q;

endmodule
